// File: rtl/aes_rnd_delay_pkg.sv
// rtl/aes_rnd_delay_pkg.sv - shared constants and state type for the random-delay start gate
package aes_rnd_delay_pkg;

  localparam int RND_W_DEF     = 13;
  localparam int DLY_W_DEF     = 4;
  localparam int MIN_DLY_DEF   = 1;
  localparam int STUCK_LIM_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

endpackage

// File: rtl/rng_health_mon.sv
// rtl/rng_health_mon.sv - stuck-at detector on the rnd stream with sticky fault
module rng_health_mon
  import aes_rnd_delay_pkg::*;
#(
  parameter int RND_W     = RND_W_DEF,
  parameter int STUCK_LIM = STUCK_LIM_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RND_W-1:0] rnd,
  output logic             rng_fault
);

  localparam int SC_W = $clog2(STUCK_LIM) + 1;
  // stuck_cnt counts equal compares; STUCK_LIM words means STUCK_LIM-1 compares
  localparam logic [SC_W-1:0] SAT  = SC_W'(STUCK_LIM - 1);
  localparam logic [SC_W-1:0] TRIP = SC_W'(STUCK_LIM - 2);

  logic [RND_W-1:0] rnd_prev;
  logic [SC_W-1:0]  stuck_cnt;

  // track previous word, count consecutive repeats, latch the fault
  always_ff @(posedge clock) begin
    if (reset) begin
      rnd_prev  <= '0;
      stuck_cnt <= '0;
      rng_fault <= 1'b0;
    end else begin
      rnd_prev <= rnd;
      if (rnd == rnd_prev) begin
        if (stuck_cnt != SAT) begin
          stuck_cnt <= stuck_cnt + 1'b1;
        end
        if (stuck_cnt >= TRIP) begin
          rng_fault <= 1'b1;
        end
      end else begin
        stuck_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/aes_rnd_delay.sv
// rtl/aes_rnd_delay.sv - random-delay start gate with dummy enable and rng health check
module aes_rnd_delay
  import aes_rnd_delay_pkg::*;
#(
  parameter int RND_W     = RND_W_DEF,
  parameter int DLY_W     = DLY_W_DEF,
  parameter int MIN_DLY   = MIN_DLY_DEF,
  parameter int STUCK_LIM = STUCK_LIM_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RND_W-1:0] rnd,
  input  logic             start_in,
  output logic             start_out,
  output logic             busy,
  output logic             dummy_en,
  output logic             overrun,
  output logic             rng_fault
);

  localparam logic [DLY_W:0] CNT_ONE = (DLY_W+1)'(1);
  localparam logic [DLY_W:0] MIN_V   = (DLY_W+1)'(MIN_DLY);

  state_t         state, state_nx;
  logic [DLY_W:0] cnt, cnt_nx;
  logic           pending, pending_nx;
  logic           overrun_q, overrun_nx;
  logic           dummy_q, dummy_nx;
  logic [DLY_W-1:0] d_sel;
  logic [DLY_W:0]   load_val;

  rng_health_mon #(
    .RND_W     (RND_W),
    .STUCK_LIM (STUCK_LIM)
  ) u_health (
    .clock     (clock),
    .reset     (reset),
    .rnd       (rnd),
    .rng_fault (rng_fault)
  );

  // a faulty RNG cannot be trusted for timing, so fall back to the longest delay
  assign d_sel    = rng_fault ? '1 : rnd[DLY_W-1:0];
  assign load_val = MIN_V + {1'b0, d_sel};

  // state, counter and flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      dummy_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pending   <= pending_nx;
      overrun_q <= overrun_nx;
      dummy_q   <= dummy_nx;
    end
  end

  // next-state, counter reload/decrement and request queuing
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pending_nx = pending;
    overrun_nx = overrun_q;
    case (state)
      ST_IDLE: begin
        if (start_in) begin
          cnt_nx   = load_val;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_ONE) begin
          state_nx = ST_FIRE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
        // one request may be held; a second one while held is lost
        if (start_in) begin
          if (pending) begin
            overrun_nx = 1'b1;
          end else begin
            pending_nx = 1'b1;
          end
        end
      end
      ST_FIRE: begin
        if (pending || start_in) begin
          cnt_nx     = load_val;
          state_nx   = ST_WAIT;
          pending_nx = 1'b0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // loaded from the next state so the enable lines up with the WAIT cycles
    dummy_nx = (state_nx == ST_WAIT) & rnd[RND_W-1];
  end

  assign start_out = (state == ST_FIRE);
  assign busy      = (state != ST_IDLE);
  assign overrun   = overrun_q;
  assign dummy_en  = dummy_q & ~rng_fault;

endmodule
